pulpino_gpio: RTL and testbench

// 32-pin GPIO peripheral of the PULPino SoC peripheral subsystem, on the APB bus.
// - Each pin has a direction bit and an output bit; pad inputs are synchronised for readback.
// - Each pin has a 6-bit pad configuration.
// - Per-pin edge/level interrupt detection feeds one interrupt line to the event unit.

---
 rtl/pulpino_gpio.sv | 114 +++++++++++
 tb/tb_pulpino_gpio.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulpino_gpio.sv
// 32-pin APB GPIO: direction/output registers, synchronised pad inputs, per-pin pad config
// and per-pin edge/level interrupt detection merged into one level interrupt line.
module pulpino_gpio (
  input  logic         clk,
  input  logic         rst,
  input  logic         psel,
  input  logic         penable,
  input  logic         pwrite,
  input  logic [11:0]  paddr,
  input  logic [31:0]  pwdata,
  output logic [31:0]  prdata,
  output logic         pready,
  output logic         pslverr,
  input  logic [31:0]  gpio_in,
  output logic [31:0]  gpio_in_sync,
  output logic [31:0]  gpio_out,
  output logic [31:0]  gpio_dir,
  output logic [191:0] gpio_padcfg,
  output logic         interrupt_o
);

  logic [31:0] sync1, sync2, sync_prev;
  logic [31:0] paddir, padout, inten, inttype0, inttype1, intstatus;
  logic [31:0] rise, fall, events;
  logic [5:0]  padcfg [32];
  logic [9:0]  waddr;
  logic [2:0]  cfg_idx;
  logic        is_cfg, wr_en, rd_status;
  logic        unused_addr_bits;

  assign waddr            = paddr[11:2];
  assign unused_addr_bits = ^paddr[1:0];
  // PADCFG0..7 occupy word addresses 8..15
  assign is_cfg    = (waddr[9:3] == 7'd1);
  assign cfg_idx   = waddr[2:0];
  assign wr_en     = psel & penable & pwrite;
  assign rd_status = psel & penable & ~pwrite & (waddr == 10'd6);

  assign pready       = 1'b1;
  assign pslverr      = 1'b0;
  assign gpio_in_sync = sync2;
  assign gpio_out     = padout;
  assign gpio_dir     = paddir;

  assign rise   = sync2 & ~sync_prev;
  assign fall   = ~sync2 & sync_prev;
  assign events = inten & ((~inttype1 & ~inttype0 & rise) |
                           (~inttype1 &  inttype0 & fall) |
                           ( inttype1 & ~inttype0 & (rise | fall)) |
                           ( inttype1 &  inttype0 & sync2));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      sync_prev   <= '0;
      paddir      <= '0;
      padout      <= '0;
      inten       <= '0;
      inttype0    <= '0;
      inttype1    <= '0;
      intstatus   <= '0;
      interrupt_o <= 1'b0;
      for (int n = 0; n < 32; n++) padcfg[5'(n)] <= '0;
    end else begin
      sync1       <= gpio_in;
      sync2       <= sync1;
      sync_prev   <= sync2;
      // A new event on the clearing edge keeps its bit set
      intstatus   <= (rd_status ? 32'h0 : intstatus) | events;
      interrupt_o <= |intstatus;
      if (wr_en) begin
        case (waddr)
          10'd0:   paddir   <= pwdata;
          10'd2:   padout   <= pwdata;
          10'd3:   inten    <= pwdata;
          10'd4:   inttype0 <= pwdata;
          10'd5:   inttype1 <= pwdata;
          default: begin
            if (is_cfg) begin
              for (int j = 0; j < 4; j++) padcfg[{cfg_idx, 2'(j)}] <= pwdata[8*j +: 6];
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (psel) begin
      case (waddr)
        10'd0:   prdata = paddir;
        10'd1:   prdata = sync2;
        10'd2:   prdata = padout;
        10'd3:   prdata = inten;
        10'd4:   prdata = inttype0;
        10'd5:   prdata = inttype1;
        10'd6:   prdata = intstatus;
        default: begin
          if (is_cfg) begin
            for (int j = 0; j < 4; j++) prdata[8*j +: 8] = {2'b00, padcfg[{cfg_idx, 2'(j)}]};
          end
        end
      endcase
    end
  end

  always_comb begin
    gpio_padcfg = '0;
    for (int n = 0; n < 32; n++) gpio_padcfg[6*n +: 6] = padcfg[5'(n)];
  end

endmodule

// File: tb/tb_pulpino_gpio.sv
// Bench for pulpino_gpio: table-driven register vectors, directed interrupt sequences and
// randomised APB traffic checked against a cycle-level reference model of the register map.
module tb_pulpino_gpio;

  logic         clk = 1'b0;
  logic         rst, psel, penable, pwrite;
  logic [11:0]  paddr;
  logic [31:0]  pwdata, prdata;
  logic         pready, pslverr;
  logic [31:0]  gpio_in, gpio_in_sync, gpio_out, gpio_dir;
  logic [191:0] gpio_padcfg;
  logic         interrupt_o;

  int checks = 0;
  int errors = 0;

  pulpino_gpio dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .gpio_padcfg(gpio_padcfg), .interrupt_o(interrupt_o)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus the last three pad samples taken at clock edges
  logic [31:0] m_dir, m_out, m_inten, m_t0, m_t1, m_status;
  logic        m_irq;
  logic [5:0]  m_cfg [32];
  logic [31:0] m_hist [3];

  function automatic logic pin_fires(input logic [1:0] code, input logic cur, input logic prev);
    case (code)
      2'd0:    return cur && !prev;
      2'd1:    return !cur && prev;
      2'd2:    return cur != prev;
      default: return cur;
    endcase
  endfunction

  function automatic int cfg_base(input logic [11:0] a);
    return (int'(a[5:2]) - 8) * 4;
  endfunction

  function automatic logic is_cfg_addr(input logic [11:0] a);
    return ({a[11:2], 2'b00} >= 12'h020) && ({a[11:2], 2'b00} <= 12'h03C);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_dir <= '0; m_out <= '0; m_inten <= '0; m_t0 <= '0; m_t1 <= '0;
      m_status <= '0; m_irq <= 1'b0;
      for (int i = 0; i < 32; i++) m_cfg[5'(i)] <= '0;
      for (int i = 0; i < 3; i++) m_hist[i] <= '0;
    end else begin
      m_hist[0] <= gpio_in;
      m_hist[1] <= m_hist[0];
      m_hist[2] <= m_hist[1];
      m_irq     <= (m_status != 0);
      for (int n = 0; n < 32; n++) begin
        m_status[n] <= (m_inten[n] && pin_fires({m_t1[n], m_t0[n]}, m_hist[1][n], m_hist[2][n]))
                    || (m_status[n] && !(psel && penable && !pwrite &&
                                         {paddr[11:2], 2'b00} == 12'h018));
      end
      if (psel && penable && pwrite) begin
        case ({paddr[11:2], 2'b00})
          12'h000: m_dir   <= pwdata;
          12'h008: m_out   <= pwdata;
          12'h00C: m_inten <= pwdata;
          12'h010: m_t0    <= pwdata;
          12'h014: m_t1    <= pwdata;
          default: if (is_cfg_addr(paddr))
            for (int j = 0; j < 4; j++) m_cfg[5'(cfg_base(paddr) + j)] <= pwdata[8*j +: 6];
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    logic [31:0] r;
    r = '0;
    case ({a[11:2], 2'b00})
      12'h000: r = m_dir;
      12'h004: r = m_hist[1];
      12'h008: r = m_out;
      12'h00C: r = m_inten;
      12'h010: r = m_t0;
      12'h014: r = m_t1;
      12'h018: r = m_status;
      default: if (is_cfg_addr(a))
        for (int j = 0; j < 4; j++) r[8*j +: 8] = {2'b00, m_cfg[5'(cfg_base(a) + j)]};
    endcase
    return r;
  endfunction

  function automatic logic [191:0] exp_padcfg();
    logic [191:0] r;
    r = '0;
    for (int n = 0; n < 32; n++) r[6*n +: 6] = m_cfg[5'(n)];
    return r;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":gpio_dir"}, 192'(gpio_dir), 192'(m_dir));
    chk({tag, ":gpio_out"}, 192'(gpio_out), 192'(m_out));
    chk({tag, ":gpio_in_sync"}, 192'(gpio_in_sync), 192'(m_hist[1]));
    chk({tag, ":gpio_padcfg"}, gpio_padcfg, exp_padcfg());
    chk({tag, ":interrupt_o"}, 192'(interrupt_o), 192'(m_irq));
    chk({tag, ":pready_pslverr"}, 192'({pready, pslverr}), 192'(2'b10));
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic [31:0] e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    e = exp_read(a);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_const(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d, e;
    apb_read(a, d, e);
    chk(name, 192'(d), 192'(exp));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[17];
  logic [11:0] alist[16];
  logic [5:0]  cfg_pin;

  initial begin
    vecs[0]  = '{1'b0, 12'h018, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 12'h000, 32'h0000_0100, 32'h0};
    vecs[2]  = '{1'b0, 12'h000, 32'h0,         32'h0000_0100};
    vecs[3]  = '{1'b1, 12'h008, 32'h0000_0100, 32'h0};
    vecs[4]  = '{1'b0, 12'h008, 32'h0,         32'h0000_0100};
    vecs[5]  = '{1'b1, 12'h024, 32'h3F00_0021, 32'h0};
    vecs[6]  = '{1'b0, 12'h024, 32'h0,         32'h3F00_0021};
    vecs[7]  = '{1'b1, 12'h020, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 12'h020, 32'h0,         32'h3F3F_3F3F};
    vecs[9]  = '{1'b1, 12'h01C, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b0, 12'h01C, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 12'h040, 32'h1234_5678, 32'h0};
    vecs[12] = '{1'b0, 12'h040, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 12'h00C, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 12'h03C, 32'hC1C2_C3C4, 32'h0};
    vecs[15] = '{1'b0, 12'h03F, 32'h0,         32'h0102_0304};
    vecs[16] = '{1'b0, 12'h004, 32'h0,         32'h0};
    alist = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h018,
              12'h01C, 12'h020, 12'h02C, 12'h030, 12'h03C, 12'h040, 12'h00C, 12'h014};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpio_in = '0;
    cycles(3);
    rst = 1'b0;
    chk("reset gpio_dir", 192'(gpio_dir), 192'(0));
    chk("reset gpio_out", 192'(gpio_out), 192'(0));
    chk("reset gpio_padcfg", gpio_padcfg, 192'(0));
    chk("reset interrupt_o", 192'(interrupt_o), 192'(0));

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else rd_const($sformatf("vec%0d read %0h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    chk("dir pin8", 192'(gpio_dir), 192'(32'h0000_0100));
    chk("out pin8", 192'(gpio_out), 192'(32'h0000_0100));
    cfg_pin = gpio_padcfg[29:24];
    chk("padcfg pin4", 192'(cfg_pin), 192'(6'h21));
    cfg_pin = gpio_padcfg[47:42];
    chk("padcfg pin7", 192'(cfg_pin), 192'(6'h3F));
    check_outputs("table");
    paddr = 12'h000;
    #1;
    chk("prdata idle", 192'(prdata), 192'(0));

    // Two-flop input synchroniser latency
    @(negedge clk); gpio_in = 32'h10;
    @(negedge clk); chk("sync after 1 clk", 192'(gpio_in_sync), 192'(0));
    @(negedge clk); chk("sync after 2 clk", 192'(gpio_in_sync), 192'(32'h10));
    rd_const("PADIN", 12'h004, 32'h10);
    gpio_in = '0;
    cycles(4);

    // Rising-edge interrupt on pin 4
    apb_write(12'h00C, 32'h10);
    apb_write(12'h010, 32'h0);
    apb_write(12'h014, 32'h0);
    rd_const("status idle", 12'h018, 32'h0);
    @(negedge clk); gpio_in = 32'h10;
    cycles(3); chk("rise irq at 3", 192'(interrupt_o), 192'(0));
    cycles(1); chk("rise irq at 4", 192'(interrupt_o), 192'(1));
    gpio_in = '0;
    rd_const("status rise", 12'h018, 32'h10);
    cycles(2); chk("irq after clear", 192'(interrupt_o), 192'(0));
    rd_const("status cleared", 12'h018, 32'h0);
    gpio_in = 32'h10;
    cycles(5); chk("second rise irq", 192'(interrupt_o), 192'(1));
    rd_const("status rise2", 12'h018, 32'h10);
    gpio_in = '0;
    cycles(4);
    rd_const("no event on fall", 12'h018, 32'h0);

    // Falling-edge type
    apb_write(12'h010, 32'h10);
    gpio_in = 32'h10;
    cycles(6); chk("fall type ignores rise", 192'(interrupt_o), 192'(0));
    gpio_in = '0;
    cycles(5); chk("fall type irq", 192'(interrupt_o), 192'(1));
    rd_const("status fall", 12'h018, 32'h10);
    cycles(2);

    // Level-high type re-sets through a clearing read; INTEN off leaves status sticky
    apb_write(12'h014, 32'h10);
    cycles(1);
    rd_const("level idle", 12'h018, 32'h0);
    gpio_in = 32'h10;
    cycles(5); chk("level irq", 192'(interrupt_o), 192'(1));
    rd_const("level status", 12'h018, 32'h10);
    rd_const("level re-set", 12'h018, 32'h10);
    apb_write(12'h00C, 32'h0);
    rd_const("sticky after inten off", 12'h018, 32'h10);
    rd_const("cleared after inten off", 12'h018, 32'h0);
    gpio_in = '0;
    check_outputs("directed");

    // Reset asserted during an access phase aborts the write
    apb_write(12'h000, 32'h1);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hFF;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    chk("abort gpio_dir", 192'(gpio_dir), 192'(0));
    check_outputs("abort");

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      logic [11:0] a;
      logic [31:0] d, e;
      if ($urandom_range(0, 1) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
      a = alist[$urandom_range(0, 15)];
      if ($urandom_range(0, 1) == 0) begin
        apb_write(a, $urandom);
      end else begin
        apb_read(a, d, e);
        chk($sformatf("rand read %0h", a), 192'(d), 192'(e));
      end
      if (it % 8 == 0) check_outputs("rand");
      else chk("rand irq", 192'(interrupt_o), 192'(m_irq));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
